// File: rtl/split_fft_input_pkg.sv
// Shared types for the FFT input splitter:
// deinterleaver state encoding and pair-word layout.
package split_fft_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2
  } state_e;

  // Pair word: {sop, eop, real_even, imag_even, real_odd, imag_odd}
  function automatic int pair_width(input int dw);
    return 4 * dw + 2;
  endfunction

endpackage

// File: rtl/split_fft_input_pair_fifo.sv
// Small first-word-fall-through FIFO holding even/odd sample pairs.
// Power-of-two depth so the pointers wrap on their own.
module split_fft_input_pair_fifo #(
  parameter int width     = 66,
  parameter int depth     = 4,
  parameter int add_width = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [width-1:0]     wr_data,
  input  logic                 pop,
  output logic [width-1:0]     rd_data,
  output logic [add_width:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [add_width:0] FULL_CNT =
    (add_width + 1)'(depth);

  logic [width-1:0]     mem_q [depth];
  logic [add_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [add_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [add_width:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/split_fft_input.sv
// Deinterleaves one complex stream into even/odd pairs for two
// half-length FFT cores, issuing both halves of a pair together.
module split_fft_input
  import split_fft_input_pkg::*;
#(
  parameter int data_width            = 16,
  parameter int transform_length      = 32768,
  parameter int log2_transform_length = 15,
  parameter int fifo_depth            = 4,
  parameter int fifo_add_width        = 2
) (
  input  logic                  clk_fft,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [data_width-1:0] in_real,
  input  logic [data_width-1:0] in_imag,
  input  logic                  sink_ready_top,
  input  logic                  sink_ready_bot,
  output logic                  sink_valid_top,
  output logic                  sink_valid_bot,
  output logic                  sink_sop_top,
  output logic                  sink_sop_bot,
  output logic                  sink_eop_top,
  output logic                  sink_eop_bot,
  output logic [data_width-1:0] sink_real_top,
  output logic [data_width-1:0] sink_imag_top,
  output logic [data_width-1:0] sink_real_bot,
  output logic [data_width-1:0] sink_imag_bot,
  output logic                  frame_error
);

  localparam int PW = pair_width(data_width);
  localparam int LW = log2_transform_length;
  localparam logic [LW-1:0] LAST_IDX = LW'(transform_length - 1);
  localparam logic [LW-1:0] ONE_IDX  = LW'(1);
  localparam logic [fifo_add_width:0] DEPTH_CNT =
    (fifo_add_width + 1)'(fifo_depth);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [data_width-1:0] re_e;
    logic [data_width-1:0] im_e;
    logic [data_width-1:0] re_o;
    logic [data_width-1:0] im_o;
  } pair_t;

  state_e                state_q, state_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic [data_width-1:0] even_re_q, even_re_d;
  logic [data_width-1:0] even_im_q, even_im_d;
  logic                  err_q, err_d;
  logic                  in_fire, at_last, push_req;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [fifo_add_width:0] fifo_count;
  logic [PW-1:0]         wr_word, rd_word;
  pair_t                 wr_pair, rd_pair;
  logic                  sink_valid;

  assign in_ready = (state_q != ST_ODD) ||
                    (fifo_count < DEPTH_CNT);
  assign in_fire  = in_valid && in_ready;
  assign at_last  = (state_q == ST_ODD) && (idx_q == LAST_IDX);

  assign wr_pair = '{
    sop:  idx_q == ONE_IDX,
    eop:  at_last,
    re_e: even_re_q,
    im_e: even_im_q,
    re_o: in_real,
    im_o: in_imag
  };
  assign wr_word   = wr_pair;
  assign fifo_push = push_req && !fifo_full;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    even_re_d = even_re_q;
    even_im_d = even_im_q;
    err_d     = 1'b0;
    push_req  = 1'b0;
    if (in_fire) begin
      // A restart makes the sample index 0, so eop can only be legal
      // on the odd sample that closes the frame.
      if (in_eop && !(at_last && !in_sop)) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
        idx_d   = '0;
      end else if (in_sop) begin
        err_d     = (state_q != ST_IDLE);
        even_re_d = in_real;
        even_im_d = in_imag;
        idx_d     = ONE_IDX;
        state_d   = ST_ODD;
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
      end else if (state_q == ST_EVEN) begin
        even_re_d = in_real;
        even_im_d = in_imag;
        idx_d     = idx_q + ONE_IDX;
        state_d   = ST_ODD;
      end else begin
        push_req = 1'b1;
        idx_d    = at_last ? '0 : idx_q + ONE_IDX;
        state_d  = at_last ? ST_IDLE : ST_EVEN;
      end
    end
  end

  always_ff @(posedge clk_fft or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      even_re_q <= '0;
      even_im_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      even_re_q <= even_re_d;
      even_im_q <= even_im_d;
      err_q     <= err_d;
    end
  end

  split_fft_input_pair_fifo #(
    .width     (PW),
    .depth     (fifo_depth),
    .add_width (fifo_add_width)
  ) u_fifo (
    .clk     (clk_fft),
    .rst_n   (reset_n),
    .push    (fifo_push),
    .wr_data (wr_word),
    .pop     (sink_valid),
    .rd_data (rd_word),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_pair = rd_word;

  // Valid only when both cores can take the pair, keeping them in lockstep.
  assign sink_valid = !fifo_empty && sink_ready_top && sink_ready_bot;

  assign sink_valid_top = sink_valid;
  assign sink_valid_bot = sink_valid;
  assign sink_sop_top   = sink_valid && rd_pair.sop;
  assign sink_sop_bot   = sink_valid && rd_pair.sop;
  assign sink_eop_top   = sink_valid && rd_pair.eop;
  assign sink_eop_bot   = sink_valid && rd_pair.eop;
  assign sink_real_top  = sink_valid ? rd_pair.re_e : '0;
  assign sink_imag_top  = sink_valid ? rd_pair.im_e : '0;
  assign sink_real_bot  = sink_valid ? rd_pair.re_o : '0;
  assign sink_imag_bot  = sink_valid ? rd_pair.im_o : '0;
  assign frame_error    = err_q;

endmodule

// File: tb/tb_split_fft_input.sv
// Bench for split_fft_input: N=16 directed/random scenarios against a
// frame-level model, plus an N=32768 back-to-back run with a scoreboard.
`timescale 1ns/1ps
module tb_split_fft_input;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int NB = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- N=16 instance ----------------
  logic rst_n = 1'b0;
  logic in_valid, in_sop, in_eop, rt, rb;
  logic [DW-1:0] in_real, in_imag;
  logic in_ready, vt, vb, sopt, sopb, eopt, eopb, ferr;
  logic [DW-1:0] rtr, rti, rbr, rbi;

  split_fft_input #(
    .data_width(DW), .transform_length(N),
    .log2_transform_length(4),
    .fifo_depth(4), .fifo_add_width(2)
  ) dut (
    .clk_fft(clk), .reset_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop),
    .in_real(in_real), .in_imag(in_imag),
    .sink_ready_top(rt), .sink_ready_bot(rb),
    .sink_valid_top(vt), .sink_valid_bot(vb),
    .sink_sop_top(sopt), .sink_sop_bot(sopb),
    .sink_eop_top(eopt), .sink_eop_bot(eopb),
    .sink_real_top(rtr), .sink_imag_top(rti),
    .sink_real_bot(rbr), .sink_imag_bot(rbi),
    .frame_error(ferr)
  );

  typedef struct {
    logic [DW-1:0] er, ei, orr, oi;
    logic sop, eop;
  } mpair_t;

  // Frame-level model: position within current frame and held even sample
  mpair_t mq[$];
  mpair_t log_q[$];
  bit m_in = 0;
  int m_pos = 0;
  logic [DW-1:0] m_hr, m_hi;
  bit exp_err = 0;
  int max_occ, err_seen, ready_low_seen;
  int first_push_cyc, first_valid_cyc;
  mpair_t cmp_pr;
  bit cmp_ev;

  function automatic bit model_accept(input bit s, input bit e,
                                      input logic [DW-1:0] r,
                                      input logic [DW-1:0] i);
    int p;
    bit err;
    mpair_t pr;
    p = s ? 0 : m_pos;
    if (!(s || m_in)) return 1'b1;
    if (e && p != N-1) begin
      m_in = 0;
      m_pos = 0;
      return 1'b1;
    end
    err = s && m_in;
    m_in = 1;
    if (p % 2 == 0) begin
      m_hr = r;
      m_hi = i;
      m_pos = p + 1;
    end else begin
      pr = '{er: m_hr, ei: m_hi, orr: r, oi: i,
             sop: (p == 1), eop: (p == N-1)};
      mq.push_back(pr);
      if (first_push_cyc < 0) first_push_cyc = cyc;
      m_pos = p + 1;
      if (p == N-1) begin
        m_in = 0;
        m_pos = 0;
      end
    end
    return err;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_in = 0;
    m_pos = 0;
    exp_err = 0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    max_occ = 0;
    err_seen = 0;
    ready_low_seen = 0;
    first_push_cyc = -1;
    first_valid_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_flags", {vt, vb, sopt, sopb, eopt, eopb, ferr}, 0);
      chk("rst_data", {rtr, rti, rbr, rbi}, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      cmp_ev = (mq.size() > 0) && rt && rb;
      chk("in_ready", in_ready,
          !(m_in && (m_pos % 2 == 1) && mq.size() >= 4));
      chk("valid_top", vt, cmp_ev);
      chk("valid_bot", vb, cmp_ev);
      chk("frame_error", ferr, exp_err);
      if (ferr) err_seen++;
      if (!in_ready) ready_low_seen++;
      if (cmp_ev && vt) begin
        cmp_pr = mq.pop_front();
        chk("top_data", {rtr, rti}, {cmp_pr.er, cmp_pr.ei});
        chk("bot_data", {rbr, rbi}, {cmp_pr.orr, cmp_pr.oi});
        chk("sop_flags", {sopt, sopb}, {cmp_pr.sop, cmp_pr.sop});
        chk("eop_flags", {eopt, eopb}, {cmp_pr.eop, cmp_pr.eop});
        log_q.push_back(cmp_pr);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      exp_err = 0;
      if (in_valid && in_ready)
        exp_err = model_accept(in_sop, in_eop, in_real, in_imag);
      if (mq.size() > max_occ) max_occ = mq.size();
    end
  end

  task automatic send(input bit s, input bit e,
                      input logic [DW-1:0] r, input logic [DW-1:0] i);
    int n = 0;
    in_valid = 1;
    in_sop = s;
    in_eop = e;
    in_real = r;
    in_imag = i;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_sop = 0;
    in_eop = 0;
  endtask

  task automatic drain();
    int n = 0;
    rt = 1;
    rb = 1;
    while (mq.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", mq.size(), 0);
  endtask

  bit rand_rdy = 0;

  task automatic run_small();
    // 1: clean frame, readies high
    clear_logs();
    rt = 1;
    rb = 1;
    for (int k = 0; k < N; k++)
      send(k == 0, k == N-1, DW'(k), DW'(-k));
    drain();
    chk("t1_pairs", log_q.size(), 8);
    chk("t1_p0", {log_q[0].er, log_q[0].orr}, {16'd0, 16'd1});
    chk("t1_p7", {log_q[7].er, log_q[7].orr}, {16'd14, 16'd15});
    chk("t1_p3_imag", {log_q[3].ei, log_q[3].oi}, {16'hFFFA, 16'hFFF9});
    chk("t1_sop_eop", {log_q[0].sop, log_q[7].eop, log_q[1].sop}, 3'b110);
    chk("t1_latency", first_valid_cyc - first_push_cyc, 1);
    chk("t1_errors", err_seen, 0);

    // 2: bottom core stalls for 10 cycles mid-frame
    clear_logs();
    fork
      for (int k = 0; k < N; k++)
        send(k == 0, k == N-1, DW'(k + 20), DW'(-k));
      begin
        repeat (4) @(posedge clk);
        #1 rb = 0;
        repeat (10) @(posedge clk);
        #1 rb = 1;
      end
    join
    drain();
    chk("t2_pairs", log_q.size(), 8);
    chk("t2_max_occ", max_occ, 4);
    chk("t2_ready_low", ready_low_seen > 0, 1);
    for (int j = 0; j < 8; j++)
      chk("t2_order", log_q[j].er, 20 + 2*j);

    // 3: early sop at sample 6
    clear_logs();
    for (int k = 0; k < 6; k++)
      send(k == 0, 0, DW'(k), DW'(-k));
    for (int k = 0; k < N; k++)
      send(k == 0, k == N-1, DW'(100 + k), DW'(-k));
    drain();
    chk("t3_pairs", log_q.size(), 11);
    chk("t3_err", err_seen, 1);
    chk("t3_p2", log_q[2].orr, 5);
    chk("t3_restart", {log_q[3].sop, log_q[3].er}, {1'b1, 16'd100});
    chk("t3_eop", {log_q[10].eop, log_q[10].orr}, {1'b1, 16'd115});

    // 4: early eop at sample 9, then a stray non-sop sample
    clear_logs();
    for (int k = 0; k < 10; k++)
      send(k == 0, k == 9, DW'(200 + k), DW'(k));
    send(0, 0, 16'd300, 16'd300);
    drain();
    chk("t4_pairs", log_q.size(), 4);
    chk("t4_err", err_seen, 2);
    chk("t4_last", {log_q[3].orr, log_q[3].eop}, {16'd207, 1'b0});

    // 5: async reset with 3 pairs queued
    clear_logs();
    rt = 0;
    rb = 0;
    for (int k = 0; k < 7; k++)
      send(k == 0, 0, DW'(k), DW'(k));
    chk("t5_queued", mq.size(), 3);
    rt = 1;
    rb = 1;
    #1 chk("t5_valid_before", vt, 1);
    rst_n = 0;
    model_reset();
    #1;
    chk("t5_rst_out", {vt, vb, sopt, rtr, rbr}, 0);
    chk("t5_rst_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    clear_logs();
    for (int k = 0; k < N; k++)
      send(k == 0, k == N-1, DW'(50 + k), DW'(k));
    drain();
    chk("t5_pairs", log_q.size(), 8);
    chk("t5_first", {log_q[0].sop, log_q[0].er, log_q[0].orr},
        {1'b1, 16'd50, 16'd51});

    // 6: random data, random readies, random gaps
    clear_logs();
    rand_rdy = 1;
    fork
      for (int f = 0; f < 3; f++)
        for (int k = 0; k < N; k++) begin
          send(k == 0, k == N-1, DW'($urandom), DW'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
      while (rand_rdy) begin
        @(posedge clk);
        #1;
        rt = ($urandom_range(0, 3) != 0);
        rb = ($urandom_range(0, 3) != 0);
      end
      begin
        wait (m_in == 0 && log_q.size() + mq.size() == 24);
        rand_rdy = 0;
      end
    join
    drain();
    chk("t6_pairs", log_q.size(), 24);
    chk("t6_err", err_seen, 0);
  endtask

  // ---------------- N=32768 instance ----------------
  logic rst_b = 1'b0;
  logic iv_b = 0, isop_b = 0, ieop_b = 0, rt_b = 1, rb_b = 1;
  logic [DW-1:0] ire_b = 0, iim_b = 0;
  logic ir_b, vt_b, vb_b, sopt_b, sopb_b, eopt_b, eopb_b, ferr_b;
  logic [DW-1:0] rtr_b, rti_b, rbr_b, rbi_b;

  split_fft_input #(
    .data_width(DW), .transform_length(NB),
    .log2_transform_length(15),
    .fifo_depth(4), .fifo_add_width(2)
  ) dut_big (
    .clk_fft(clk), .reset_n(rst_b),
    .in_valid(iv_b), .in_ready(ir_b),
    .in_sop(isop_b), .in_eop(ieop_b),
    .in_real(ire_b), .in_imag(iim_b),
    .sink_ready_top(rt_b), .sink_ready_bot(rb_b),
    .sink_valid_top(vt_b), .sink_valid_bot(vb_b),
    .sink_sop_top(sopt_b), .sink_sop_bot(sopb_b),
    .sink_eop_top(eopt_b), .sink_eop_bot(eopb_b),
    .sink_real_top(rtr_b), .sink_imag_top(rti_b),
    .sink_real_bot(rbr_b), .sink_imag_bot(rbi_b),
    .frame_error(ferr_b)
  );

  function automatic logic [DW-1:0] bre(input int g);
    return DW'(g * 40503 + 17);
  endfunction

  function automatic logic [DW-1:0] bim(input int g);
    return DW'(g) ^ 16'h5A5A;
  endfunction

  int bpops = 0, bsops = 0, beops = 0, bferr = 0;

  // Pair p of the stream holds global samples 2p and 2p+1
  always @(negedge clk) begin
    if (rst_b) begin
      if (ferr_b) bferr++;
      if (vt_b || vb_b) begin
        chk("big_pair",
            {vt_b, vb_b, rt_b, rb_b, sopt_b, sopb_b, eopt_b, eopb_b,
             rtr_b, rti_b, rbr_b, rbi_b},
            {4'hF,
             {2{(bpops % (NB/2)) == 0}},
             {2{(bpops % (NB/2)) == NB/2 - 1}},
             bre(2*bpops), bim(2*bpops),
             bre(2*bpops + 1), bim(2*bpops + 1)});
        bsops += int'(sopt_b);
        beops += int'(eopt_b);
        bpops++;
      end
    end
  end

  task automatic run_big();
    int g = 0;
    int n = 0;
    bit acc;
    repeat (2) @(posedge clk);
    #2 rst_b = 1;
    while (g < 2*NB && n < 80000) begin
      iv_b = 1;
      isop_b = (g % NB) == 0;
      ieop_b = (g % NB) == NB - 1;
      ire_b = bre(g);
      iim_b = bim(g);
      rt_b = ($urandom_range(0, 6) != 0);
      rb_b = ($urandom_range(0, 6) != 0);
      @(negedge clk);
      acc = iv_b && ir_b;
      @(posedge clk);
      #1;
      if (acc) g++;
      n++;
    end
    iv_b = 0;
    rt_b = 1;
    rb_b = 1;
    chk("big_inputs", g, 2*NB);
    n = 0;
    while (bpops < NB && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("big_pairs", bpops, NB);
    chk("big_sops", bsops, 2);
    chk("big_eops", beops, 2);
    chk("big_ferr", bferr, 0);
  endtask

  initial begin
    in_valid = 0;
    in_sop = 0;
    in_eop = 0;
    in_real = 0;
    in_imag = 0;
    rt = 1;
    rb = 1;
    clear_logs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    fork
      run_small();
      run_big();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
